ws2812_string_receiver: RTL
===========================

// Module: ws2812_string_receiver
// PURPOSE
//  Decodes a WS2812B-style serial line (the sdi stream our string driver emits) back into 24-bit pixels.
//  Used for loopback self-test of the LED pipeline and to capture DOUT of the last LED in a string.
//  Bits are classified by LOW-phase width, because the transmitter may stretch the high phase while idle.
//  Frames are delimited by the >=50 us low reset/blank pulse.
// PARAMETERS
//  CLK_PERIOD_NS  100    clk period in ns; every threshold is ceil(ns/CLK_PERIOD_NS) cycles
//  THRESH_NS      650    low phase < THRESH cycles -> bit 1, otherwise bit 0
//  MIN_LOW_NS     200    low phase < MIN_LOW cycles -> glitch, bit_error
//  RESET_NS       40000  low phase >= RESET cycles -> frame boundary (below the driver's 50 us blank)
//  CNT_W          16     width of the saturating low-phase counter
// PORTS
//  clk               in   1   system clock
//  rst_n             in   1   asynchronous, active-low reset
//  sdo_in            in   1   asynchronous serial line; idles high between bits
//  pixel_data        out  24  last decoded pixel, MSB first on wire; holds until next pixel
//  pixel_data_valid  out  1   one-cycle strobe; pixel_data is valid in the same cycle
//  frame_done        out  1   one-cycle strobe: reset seen after a whole number of pixels (>=1)
//  frame_pixels      out  16  pixel count of the last frame; updated with frame_done
//  bit_error         out  1   sticky: glitch or partial pixel at frame end
//  err_clear         in   1   clears bit_error; a new error in the same cycle wins
//  in_sync           out  1   high once the first reset pulse has been seen after rst_n
// BEHAVIOUR
//  Reset values: all outputs 0, state HUNT, counters 0.
//  Input path:
//   - sdo_in passes a 2-flop synchroniser to give sdo_s.
//   - Edges are detected against a registered copy of sdo_s.
//  Low counter:
//   - cleared on the falling edge, +1 per low cycle.
//   - saturates at 2^CNT_W-1 with no wrap.
//  FSM states:
//   - HUNT: ignores edges. Low counter reaching RESET -> BLANK and sets in_sync; no frame_done.
//   - BLANK: line low past reset. Rising edge -> HIGH, bit_cnt=0, pix_cnt=0.
//   - HIGH: no width limit. Falling edge -> LOW.
//   - LOW, rising edge with cnt < MIN_LOW: set bit_error, drop the partial pixel (bit_cnt=0), -> HIGH.
//   - LOW, rising edge otherwise: shift in bit (cnt<THRESH ? 1:0) at LSB with MSB first, bit_cnt+1, -> HIGH.
//   - LOW, on bit 24: pixel_data and pixel_data_valid are registered next cycle; bit_cnt=0; pix_cnt+1, saturating at 0xFFFF.
//   - LOW, cnt reaching RESET exactly (fires once): -> BLANK.
//     - bit_cnt==0 and pix_cnt>0: pulse frame_done, latch frame_pixels.
//     - bit_cnt!=0: set bit_error, no frame_done.
//     - pix_cnt==0: no strobe.
//  Latency: sdo_in rise ending bit 24 -> pixel_data_valid = 4 clk (2 sync + edge reg + output reg).
//  frame_done asserts RESET+3 clk after the falling edge at sdo_in.
//  Only classify/shift happens on an edge; there are no simultaneous-edge cases per cycle.
//  pixel_data_valid and frame_done are never high in the same cycle.
//  rst_n is asynchronous: deassert mid-frame, then wait in HUNT for the next reset pulse. Partial data is discarded.
// CONFIGURATION
//  WS2812_RX_GLITCH_FILTER_EN:
//   - defined: 3-sample majority filter after the synchroniser. Isolated 1-cycle pulses are rejected.
//   - defined: every edge-relative latency above is +2 clk; widths are unchanged.
//  Undefined: sdo_s is used directly, and a 1-cycle glitch is reported as a bit_error.
// TESTING (10 MHz clk, defaults: THRESH=7, MIN_LOW=2, RESET=400 cycles)
//  1. rst_n release, line high, then 50 us low -> in_sync=1, no frame_done.
//  2. Send 0xA5C30F (bit 1: H8/L4 cycles; bit 0: H4/L9), then 50 us low.
//     -> pixel_data=0xA5C30F with a 1-cycle valid; frame_done with frame_pixels=1.
//  3. Three pixels with 20 us high stretch between pixels 1 and 2, then blank.
//     -> three valid strobes, correct data, frame_pixels=3.
//  4. 10 bits then 50 us low -> bit_error=1, no valid, no frame_done.
//     Then err_clear pulse -> bit_error=0.
//  5. 1-cycle low glitch mid-bit -> bit_error=1 without _EN.
//     Same stimulus with _EN -> no error, pixel decoded unchanged.
//  6. Assert rst_n mid-pixel -> outputs 0 immediately. After release, next frame is ignored until blank, then decodes.

Source files
------------

// File: rtl/ws2812_string_receiver.sv
// ws2812_string_receiver
//   Decodes a WS2812B-style serial line back into 24-bit pixels. Bits are
//   classified by the width of their low phase. A long low pulse marks a frame
//   boundary. Used for loopback self-test and to capture DOUT of the last LED.
//
//   Optional build macro WS2812_RX_GLITCH_FILTER_EN adds a 3-sample majority
//   filter after the synchroniser. The filter rejects isolated 1-cycle pulses
//   and adds 2 clk to every edge-relative latency.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// HUNT   | after rst_n; ignore edges until the first reset pulse is seen
// BLANK  | line low past the reset width; waiting for the first rising edge
// HIGH   | high phase of a bit (any width); waiting for the falling edge
// LOW    | low phase of a bit; the next rising edge classifies the bit
module ws2812_string_receiver #(
   parameter int CLK_PERIOD_NS = 100,
   parameter int THRESH_NS     = 650,
   parameter int MIN_LOW_NS    = 200,
   parameter int RESET_NS      = 40000,
   parameter int CNT_W         = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        sdo_in,
   output logic [23:0] pixel_data,
   output logic        pixel_data_valid,
   output logic        frame_done,
   output logic [15:0] frame_pixels,
   output logic        bit_error,
   input  logic        err_clear,
   output logic        in_sync
);

   localparam int THRESH_CYC  = (THRESH_NS  + CLK_PERIOD_NS - 1) / CLK_PERIOD_NS;
   localparam int MIN_LOW_CYC = (MIN_LOW_NS + CLK_PERIOD_NS - 1) / CLK_PERIOD_NS;
   localparam int RESET_CYC   = (RESET_NS   + CLK_PERIOD_NS - 1) / CLK_PERIOD_NS;

   localparam logic [CNT_W-1:0] THRESH_C  = CNT_W'(THRESH_CYC);
   localparam logic [CNT_W-1:0] MIN_LOW_C = CNT_W'(MIN_LOW_CYC);
   localparam logic [CNT_W-1:0] RESET_C   = CNT_W'(RESET_CYC);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   typedef enum logic [1:0] {
      ST_HUNT,
      ST_BLANK,
      ST_HIGH,
      ST_LOW
   } state_t;

   state_t state, state_nxt;

   logic sync_q1, sync_q2;
   logic sdo_s, sdo_d;
   logic rise, fall;

   logic [CNT_W-1:0] low_cnt;
   logic             reset_hit;

   logic [4:0]  bit_cnt;
   logic [15:0] pix_cnt;
   logic [23:0] shreg;
   logic        pix_pend;

   logic start_frame, shift_en, pixel_end, glitch;
   logic frame_ok, frame_err, sync_set;
   logic bit_val;

   // two-flop synchroniser for the asynchronous serial line
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q1 <= 1'b0;
         sync_q2 <= 1'b0;
      end else begin
         sync_q1 <= sdo_in;
         sync_q2 <= sync_q1;
      end
   end

`ifdef WS2812_RX_GLITCH_FILTER_EN
   logic maj_d1, maj_d2, sdo_f;

   // majority of the last three synchronised samples; a lone 1-cycle pulse never wins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         maj_d1 <= 1'b0;
         maj_d2 <= 1'b0;
         sdo_f  <= 1'b0;
      end else begin
         maj_d1 <= sync_q2;
         maj_d2 <= maj_d1;
         sdo_f  <= (sync_q2 & maj_d1) | (sync_q2 & maj_d2) | (maj_d1 & maj_d2);
      end
   end

   assign sdo_s = sdo_f;
`else
   assign sdo_s = sync_q2;
`endif

   assign rise      = sdo_s & ~sdo_d;
   assign fall      = ~sdo_s & sdo_d;
   assign reset_hit = (low_cnt == RESET_C);
   assign bit_val   = (low_cnt < THRESH_C);

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_HUNT;
      else        state <= state_nxt;
   end

   // next-state decode and per-cycle datapath controls
   always_comb begin
      state_nxt   = state;
      start_frame = 1'b0;
      shift_en    = 1'b0;
      pixel_end   = 1'b0;
      glitch      = 1'b0;
      frame_ok    = 1'b0;
      frame_err   = 1'b0;
      sync_set    = 1'b0;
      case (state)
         ST_HUNT: begin
            if (reset_hit) begin
               sync_set = 1'b1;
               if (rise) begin
                  state_nxt   = ST_HIGH;
                  start_frame = 1'b1;
               end else begin
                  state_nxt = ST_BLANK;
               end
            end
         end
         ST_BLANK: begin
            if (rise) begin
               state_nxt   = ST_HIGH;
               start_frame = 1'b1;
            end
         end
         ST_HIGH: begin
            if (fall) state_nxt = ST_LOW;
         end
         ST_LOW: begin
            if (reset_hit) begin
               // low counter only equals RESET for one cycle, so this fires once
               if (bit_cnt != 5'd0)      frame_err = 1'b1;
               else if (pix_cnt != 16'd0) frame_ok = 1'b1;
               if (rise) begin
                  state_nxt   = ST_HIGH;
                  start_frame = 1'b1;
               end else begin
                  state_nxt = ST_BLANK;
               end
            end else if (rise) begin
               state_nxt = ST_HIGH;
               if (low_cnt < MIN_LOW_C) begin
                  glitch = 1'b1;
               end else begin
                  shift_en  = 1'b1;
                  pixel_end = (bit_cnt == 5'd23);
               end
            end
         end
         default: state_nxt = ST_HUNT;
      endcase
   end

   // edge register, saturating low-phase counter, bit/pixel assembly and outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sdo_d            <= 1'b0;
         low_cnt          <= '0;
         bit_cnt          <= 5'd0;
         pix_cnt          <= 16'd0;
         shreg            <= 24'd0;
         pix_pend         <= 1'b0;
         pixel_data       <= 24'd0;
         pixel_data_valid <= 1'b0;
         frame_done       <= 1'b0;
         frame_pixels     <= 16'd0;
         bit_error        <= 1'b0;
         in_sync          <= 1'b0;
      end else begin
         sdo_d <= sdo_s;

         // held at zero while high, so the first low cycle counts as 1
         if (sdo_s)                   low_cnt <= '0;
         else if (low_cnt != CNT_MAX) low_cnt <= low_cnt + 1'b1;

         if (start_frame) begin
            bit_cnt <= 5'd0;
            pix_cnt <= 16'd0;
         end else if (glitch) begin
            bit_cnt <= 5'd0;
         end else if (shift_en) begin
            shreg <= {shreg[22:0], bit_val};
            if (pixel_end) begin
               bit_cnt <= 5'd0;
               if (pix_cnt != 16'hFFFF) pix_cnt <= pix_cnt + 16'd1;
            end else begin
               bit_cnt <= bit_cnt + 5'd1;
            end
         end

         pix_pend         <= pixel_end;
         pixel_data_valid <= pix_pend;
         if (pix_pend) pixel_data <= shreg;

         frame_done <= frame_ok;
         if (frame_ok) frame_pixels <= pix_cnt;

         bit_error <= glitch | frame_err | (bit_error & ~err_clear);
         in_sync   <= in_sync | sync_set;
      end
   end

endmodule
